pixel_data_mem: RTL and testbench
=================================

// Module: pixel_data_mem
// PURPOSE
//  Data-memory responder for the filter GPU's 3-lane pixel data port (A1/A2/A3, writeData, ReadData, MemWrite).
//  Serves GPU lane reads and writes with 1-cycle read latency.
//  Exposes a host streaming port that loads an image before filtering and dumps it after, stalling the GPU meanwhile.
// PARAMETERS
//  DATA_W     18    pixel word width (one lane)
//  ADDR_W     10    word address width
//  LANES      3     GPU lanes served in parallel
//  IMG_WORDS  1024  words moved per host load/dump (<= 2**ADDR_W)
// PORTS
//  CLK         in   1                 single clock, rising edge
//  RST         in   1                 synchronous, active-high reset
//  A1,A2,A3    in   ADDR_W            GPU lane 0/1/2 addresses
//  MemWrite    in   1                 GPU write enable, all lanes
//  writeData   in   [LANES][DATA_W]   GPU write data, lane i <-> A(i+1)
//  ReadData    out  [LANES][DATA_W]   GPU read data, 1 cycle after address
//  gpu_stall   out  1                 1 = host owns memory; GPU must hold
//  load_start  in   1                 pulse: begin host load at addr 0
//  ld_valid    in   1                 host load beat valid
//  ld_data     in   DATA_W            host load word
//  ld_ready    out  1                 block accepts load beat
//  dump_start  in   1                 pulse: begin host dump at addr 0
//  dump_valid  out  1                 dump word valid
//  dump_data   out  DATA_W            dump word
//  dump_ready  in   1                 host accepts dump word
//  xfer_done   out  1                 1-cycle pulse at end of load or dump
// BEHAVIOUR
//  Reset: state=IDLE, addr counter=0. ReadData=0, gpu_stall=0, ld_ready=0, dump_valid=0, dump_data=0, xfer_done=0.
//    Array contents are not reset.
//  FSM states: IDLE, LOAD, DUMP_FETCH, DUMP_OUT.
//  IDLE:
//    - load_start -> LOAD.
//    - dump_start -> DUMP_FETCH.
//    - Both asserted in the same cycle: LOAD wins.
//    - gpu_stall=0 only in IDLE.
//  GPU reads (every cycle):
//    - ReadData[i] <= mem[A(i+1)].
//    - Read-during-write on the same address returns old data.
//  GPU writes (IDLE && MemWrite): mem[A(i+1)] <= writeData[i] for all lanes.
//    - Same address on several lanes: highest lane index wins.
//    - MemWrite outside IDLE is ignored.
//  LOAD:
//    - ld_ready=1.
//    - Each beat with ld_valid&&ld_ready writes mem[cnt] <= ld_data, then cnt++.
//    - Beat at cnt==IMG_WORDS-1: xfer_done pulse next cycle, cnt=0, -> IDLE.
//  DUMP_FETCH: issue read of mem[cnt] (1-cycle latency), -> DUMP_OUT.
//  DUMP_OUT:
//    - dump_valid=1; dump_data holds until dump_valid&&dump_ready.
//    - On handshake, cnt++ and -> DUMP_FETCH.
//    - At last word: xfer_done pulse, cnt=0, -> IDLE.
//  Throughput: load 1 word/cycle; dump 1 word per 2 cycles.
//  load_start/dump_start outside IDLE are ignored.
//  cnt wraps only via the terminal compare; it never exceeds IMG_WORDS-1.
//  RST mid-transfer: immediate return to IDLE.
//    Partially loaded words remain in memory; no xfer_done.
// STRUCTURE
//  Shared package gpu_mem_pkg: DATA_W, ADDR_W, LANES, pixel_t (logic [DATA_W-1:0]), mem_state_e enum.
//  One sub-module: pixel_ram (2**ADDR_W x DATA_W).
//    LANES synchronous read ports, LANES write ports with lane-priority merge, plus one host port.
//  FSM, counter and arbitration live in pixel_data_mem.
// TESTING
//  1. Load: load_start, 1024 beats ld_data=addr^18'h155 with ld_valid held.
//     -> ld_ready=1 throughout; xfer_done after beat 1024; gpu_stall 1->0.
//  2. GPU lane read: A1=5, A2=6, A3=1023 after test 1.
//     -> next cycle ReadData = {5^155, 6^155, 3FF^155} (hex).
//  3. Lane conflict: MemWrite, A1=A2=A3=10, writeData={3'h1,2,3}.
//     -> reading addr 10 returns 3 (lane 2).
//     Read-during-write on addr 10 returns the previous value.
//  4. Dump with backpressure: dump_start, dump_ready toggling 1010...
//     -> 1024 words in order, dump_data stable while !dump_ready, single xfer_done.
//  5. Collisions: load_start and dump_start together -> LOAD entered.
//     MemWrite during LOAD -> memory unchanged by GPU.
//  6. RST after 300 load beats -> IDLE next cycle, gpu_stall=0.
//     Addrs 0..299 hold loaded data; no xfer_done.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared types and sizes for the GPU pixel data memory.
// Revision 1.0
`default_nettype none

package gpu_mem_pkg;

   localparam int DATA_W = 18;
   localparam int ADDR_W = 10;
   localparam int LANES  = 3;

   typedef logic [DATA_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD       = 2'd1,
      DUMP_FETCH = 2'd2,
      DUMP_OUT   = 2'd3
   } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/pixel_ram.sv
// Pixel storage: per-lane synchronous read/write ports plus one host port.
// Revision 1.0
`default_nettype none

module pixel_ram
   import gpu_mem_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [LANES-1:0][ADDR_W-1:0]  lane_addr,
   input  logic                          lane_we,
   input  logic [LANES-1:0][DATA_W-1:0]  lane_wdata,
   output logic [LANES-1:0][DATA_W-1:0]  lane_rdata,
   input  logic                          host_we,
   input  logic [ADDR_W-1:0]             host_addr,
   input  pixel_t                        host_wdata,
   output pixel_t                        host_rdata
);

   pixel_t mem [2**ADDR_W];

   // Later lanes are assigned last, so the highest lane wins on an address clash.
   always_ff @(posedge clk) begin
      if (lane_we) begin
         for (int i = 0; i < LANES; i++) begin
            mem[lane_addr[i]] <= lane_wdata[i];
         end
      end else if (host_we) begin
         mem[host_addr] <= host_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_rdata <= '0;
         host_rdata <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            lane_rdata[i] <= mem[lane_addr[i]];
         end
         host_rdata <= mem[host_addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/pixel_data_mem.sv
// GPU 3-lane data memory with a host load/dump streaming port that stalls the GPU.
// Revision 1.0
`default_nettype none

module pixel_data_mem
   import gpu_mem_pkg::*;
#(
   parameter int IMG_WORDS = 1024
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [ADDR_W-1:0]             A1,
   input  logic [ADDR_W-1:0]             A2,
   input  logic [ADDR_W-1:0]             A3,
   input  logic                          MemWrite,
   input  logic [LANES-1:0][DATA_W-1:0]  writeData,
   output logic [LANES-1:0][DATA_W-1:0]  ReadData,
   output logic                          gpu_stall,
   input  logic                          load_start,
   input  logic                          ld_valid,
   input  pixel_t                        ld_data,
   output logic                          ld_ready,
   input  logic                          dump_start,
   output logic                          dump_valid,
   output pixel_t                        dump_data,
   input  logic                          dump_ready,
   output logic                          xfer_done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_WORDS - 1);

   mem_state_e        state, next_state;
   logic [ADDR_W-1:0] cnt;
   logic              lane_we, host_we;
   logic              load_beat, dump_hs, at_last;
   pixel_t            host_rdata;

   assign load_beat = (state == LOAD) && ld_valid;
   assign dump_hs   = (state == DUMP_OUT) && dump_ready;
   assign at_last   = (cnt == LAST);

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (load_start)      next_state = LOAD;
            else if (dump_start) next_state = DUMP_FETCH;
         end
         LOAD:       if (load_beat && at_last) next_state = IDLE;
         DUMP_FETCH: next_state = DUMP_OUT;
         DUMP_OUT:   if (dump_hs) next_state = at_last ? IDLE : DUMP_FETCH;
         default:    next_state = IDLE;
      endcase
   end

   // Host read data stays stable in DUMP_OUT: cnt is frozen and nothing writes the array.
   always_comb begin
      gpu_stall  = (state != IDLE);
      ld_ready   = (state == LOAD);
      dump_valid = (state == DUMP_OUT);
      dump_data  = (state == DUMP_OUT) ? host_rdata : '0;
      lane_we    = (state == IDLE) && MemWrite;
      host_we    = load_beat;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt       <= '0;
         xfer_done <= 1'b0;
      end else begin
         xfer_done <= (load_beat || dump_hs) && at_last;
         if (load_beat || dump_hs) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
         end
      end
   end

   pixel_ram u_ram (
      .clk        (CLK),
      .rst        (RST),
      .lane_addr  ({A3, A2, A1}),
      .lane_we    (lane_we),
      .lane_wdata (writeData),
      .lane_rdata (ReadData),
      .host_we    (host_we),
      .host_addr  (cnt),
      .host_wdata (ld_data),
      .host_rdata (host_rdata)
   );

endmodule

`default_nettype wire

// File: tb/tb_pixel_data_mem.sv
// Self-checking bench for pixel_data_mem against an array-based memory model.
// Revision 1.0
`default_nettype none

module tb_pixel_data_mem;
   import gpu_mem_pkg::*;

   logic                         CLK = 1'b0;
   logic                         RST;
   logic [ADDR_W-1:0]            A1, A2, A3;
   logic                         MemWrite;
   logic [LANES-1:0][DATA_W-1:0] writeData;
   logic [LANES-1:0][DATA_W-1:0] ReadData;
   logic                         gpu_stall;
   logic                         load_start, ld_valid, ld_ready;
   pixel_t                       ld_data;
   logic                         dump_start, dump_valid, dump_ready;
   pixel_t                       dump_data;
   logic                         xfer_done;

   int     vectors = 0;
   int     miscompares = 0;
   pixel_t model [1024];

   typedef struct {
      logic [9:0]  a1, a2, a3;
      logic [17:0] e0, e1, e2;
   } rd_vec_t;

   rd_vec_t rd_tab [3];

   always #5 CLK = ~CLK;

   pixel_data_mem #(.IMG_WORDS(1024)) dut (
      .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .A3(A3), .MemWrite(MemWrite),
      .writeData(writeData), .ReadData(ReadData), .gpu_stall(gpu_stall),
      .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .dump_start(dump_start), .dump_valid(dump_valid), .dump_data(dump_data),
      .dump_ready(dump_ready), .xfer_done(xfer_done)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic read_check(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2, input string name);
      A1 = a0; A2 = a1; A3 = a2; MemWrite = 1'b0;
      step();
      check({name, "_l0"}, ReadData[0], model[a0]);
      check({name, "_l1"}, ReadData[1], model[a1]);
      check({name, "_l2"}, ReadData[2], model[a2]);
   endtask

   initial begin
      int idx, dones, loaded;
      logic   have_prev;
      pixel_t prev_data;
      logic [9:0] ra [3];
      pixel_t exp_rd [3];

      rd_tab[0] = '{10'd5, 10'd6, 10'd1023, 18'h150, 18'h153, 18'h2AA};
      rd_tab[1] = '{10'd0, 10'd1, 10'd2,    18'h155, 18'h154, 18'h157};
      rd_tab[2] = '{10'd1023, 10'd512, 10'd7, 18'h2AA, 18'h355, 18'h152};

      RST = 1'b1; A1 = '0; A2 = '0; A3 = '0; MemWrite = 1'b0; writeData = '0;
      load_start = 1'b0; ld_valid = 1'b0; ld_data = '0; dump_start = 1'b0; dump_ready = 1'b0;
      step(); step();
      check("rst_readdata", ReadData, 0);
      check("rst_stall", gpu_stall, 0);
      check("rst_ld_ready", ld_ready, 0);
      check("rst_dump_valid", dump_valid, 0);
      check("rst_dump_data", dump_data, 0);
      check("rst_xfer_done", xfer_done, 0);
      RST = 1'b0;
      step();

      // Full image load, one beat per cycle
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      check("load_stall", gpu_stall, 1);
      for (int i = 0; i < 1024; i++) begin
         ld_valid = 1'b1;
         ld_data  = pixel_t'(i) ^ 18'h155;
         check("load_ready", ld_ready, 1);
         step();
         model[i] = pixel_t'(i) ^ 18'h155;
         if (i < 1023) check("load_early_done", xfer_done, 0);
      end
      ld_valid = 1'b0;
      check("load_done", xfer_done, 1);
      check("load_stall_end", gpu_stall, 0);
      step();
      check("load_done_pulse", xfer_done, 0);

      // Table-driven lane reads with literal expectations
      for (int k = 0; k < 3; k++) begin
         A1 = rd_tab[k].a1; A2 = rd_tab[k].a2; A3 = rd_tab[k].a3;
         step();
         check("tab_l0", ReadData[0], rd_tab[k].e0);
         check("tab_l1", ReadData[1], rd_tab[k].e1);
         check("tab_l2", ReadData[2], rd_tab[k].e2);
      end

      // All lanes write address 10; lane 2 must win, read-during-write sees old data
      A1 = 10'd10; A2 = 10'd10; A3 = 10'd10; MemWrite = 1'b1;
      writeData[0] = 18'd1; writeData[1] = 18'd2; writeData[2] = 18'd3;
      step();
      check("rdw_old", ReadData[0], 18'h15F);
      MemWrite = 1'b0;
      step();
      model[10] = 18'd3;
      check("lane_prio", ReadData[0], 18'd3);
      check("lane_prio_l2", ReadData[2], 18'd3);

      // Random GPU traffic; model applies writes in lane order after sampling reads
      for (int c = 0; c < 200; c++) begin
         for (int l = 0; l < 3; l++) begin
            ra[l] = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(8, 15)) : 10'($urandom_range(0, 1023));
            writeData[l] = 18'($urandom);
            exp_rd[l] = model[ra[l]];
         end
         A1 = ra[0]; A2 = ra[1]; A3 = ra[2];
         MemWrite = ($urandom_range(0, 2) == 0);
         if (MemWrite) for (int l = 0; l < 3; l++) model[ra[l]] = writeData[l];
         step();
         for (int l = 0; l < 3; l++) check("rand_rd", ReadData[l], exp_rd[l]);
      end
      MemWrite = 1'b0;

      // Dump with alternating backpressure; stray load_start must be ignored
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      idx = 0; dones = 0; have_prev = 1'b0; prev_data = '0;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         dump_ready = (cyc % 2 == 0);
         load_start = (cyc == 7);
         if (dump_valid) begin
            if (have_prev) check("dump_hold", dump_data, prev_data);
            if (dump_ready) begin
               if (idx < 1024) check("dump_word", dump_data, model[idx]);
               else            check("dump_extra", idx, 1023);
               idx++;
               have_prev = 1'b0;
            end else begin
               have_prev = 1'b1;
               prev_data = dump_data;
            end
         end
         step();
         if (xfer_done) dones++;
         if (!gpu_stall) break;
      end
      load_start = 1'b0; dump_ready = 1'b0;
      check("dump_count", idx, 1024);
      check("dump_xfer_done", dones, 1);
      check("dump_stall_end", gpu_stall, 0);
      step();

      // Simultaneous starts: load wins; GPU writes during load are dropped
      load_start = 1'b1; dump_start = 1'b1;
      step();
      load_start = 1'b0; dump_start = 1'b0;
      check("collide_ld_ready", ld_ready, 1);
      check("collide_dump_valid", dump_valid, 0);
      A1 = 10'd20; A2 = 10'd20; A3 = 10'd20; MemWrite = 1'b1;
      writeData = {18'h3FFFF, 18'h2AAAA, 18'h15555};
      step(); step(); step();
      MemWrite = 1'b0;
      step();
      check("gpu_wr_blocked", ReadData[0], model[20]);

      // Partial load with gaps, then reset after 300 beats
      loaded = 0;
      for (int cyc = 0; cyc < 2000 && loaded < 300; cyc++) begin
         ld_valid = ($urandom_range(0, 3) != 0);
         ld_data  = pixel_t'(loaded) ^ 18'h0AB;
         if (ld_valid) model[loaded] = pixel_t'(loaded) ^ 18'h0AB;
         step();
         if (ld_valid) loaded++;
         check("part_no_done", xfer_done, 0);
      end
      ld_valid = 1'b0;
      check("part_beats", loaded, 300);
      RST = 1'b1;
      step();
      RST = 1'b0;
      check("rst_mid_stall", gpu_stall, 0);
      check("rst_mid_ld_ready", ld_ready, 0);
      check("rst_mid_done", xfer_done, 0);
      step();
      check("rst_mid_done2", xfer_done, 0);
      read_check(10'd0, 10'd299, 10'd300, "part_edge");
      for (int k = 0; k < 40; k++) begin
         read_check(10'($urandom_range(0, 299)), 10'($urandom_range(0, 1023)),
                    10'($urandom_range(300, 1023)), "part_rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
